// File: rtl/bounded_counter.sv
// Parametrised up/down bounded counter with saturate/wrap modes,
// clamped parallel load and registered terminal-count/wrap pulses.
module bounded_counter #(
  parameter int WIDTH     = 6,
  parameter int MAX_COUNT = 33
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ena,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             wrap,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             tc,
  output logic             wrapped
);

  if (MAX_COUNT < 1 || MAX_COUNT > (2**WIDTH) - 1) begin : g_bad
    $error("bounded_counter: MAX_COUNT out of range");
  end

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_n;
  logic             tc_n;
  logic             wrapped_n;

  assign at_max = (count == MAXV);
  assign at_min = (count == ZERO);

  // Bounds are produced explicitly, never via natural overflow.
  always_comb begin
    count_n   = count;
    tc_n      = 1'b0;
    wrapped_n = 1'b0;
    if (clr) begin
      count_n = ZERO;
    end else if (load) begin
      count_n = (load_val > MAXV) ? MAXV : load_val;
    end else if (count > MAXV) begin
      count_n = ZERO;
    end else if (ena) begin
      if (!dir) begin
        if (count != MAXV) begin
          count_n = count + ONE;
          tc_n    = (count_n == MAXV);
        end else if (wrap) begin
          count_n   = ZERO;
          wrapped_n = 1'b1;
        end
      end else begin
        if (count != ZERO) begin
          count_n = count - ONE;
          tc_n    = (count_n == ZERO);
        end else if (wrap) begin
          count_n   = MAXV;
          wrapped_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count   <= ZERO;
      tc      <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      count   <= count_n;
      tc      <= tc_n;
      wrapped <= wrapped_n;
    end
  end

endmodule

// File: tb/tb_bounded_counter.sv
// Randomised and directed bench for bounded_counter at three
// parameter points, checked against an arithmetic reference model.
module tb_bounded_counter;

  logic       clock = 1'b0;
  logic       reset;
  logic       ena, clr, load, dir, wrap;
  logic [7:0] lv;

  logic [5:0] c0;
  logic [3:0] c1;
  logic [7:0] c2;
  logic [2:0] amx, amn, tcv, wrv;

  int checks = 0;
  int errors = 0;

  int mx[3] = '{33, 15, 200};
  int wm[3] = '{63, 15, 255};
  int mc[3];
  bit mt[3];
  bit mw[3];

  always #5 clock = ~clock;

  bounded_counter #(.WIDTH(6), .MAX_COUNT(33)) u0 (
    .clock(clock), .reset(reset), .ena(ena), .clr(clr),
    .load(load), .load_val(lv[5:0]), .dir(dir), .wrap(wrap),
    .count(c0), .at_max(amx[0]), .at_min(amn[0]),
    .tc(tcv[0]), .wrapped(wrv[0])
  );

  bounded_counter #(.WIDTH(4), .MAX_COUNT(15)) u1 (
    .clock(clock), .reset(reset), .ena(ena), .clr(clr),
    .load(load), .load_val(lv[3:0]), .dir(dir), .wrap(wrap),
    .count(c1), .at_max(amx[1]), .at_min(amn[1]),
    .tc(tcv[1]), .wrapped(wrv[1])
  );

  bounded_counter #(.WIDTH(8), .MAX_COUNT(200)) u2 (
    .clock(clock), .reset(reset), .ena(ena), .clr(clr),
    .load(load), .load_val(lv), .dir(dir), .wrap(wrap),
    .count(c2), .at_max(amx[2]), .at_min(amn[2]),
    .tc(tcv[2]), .wrapped(wrv[2])
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: one clock step from the operation rules.
  function automatic void step(
    input int m, input int c, input bit cl, input bit ld,
    input bit en, input bit dr, input bit wp, input int v,
    output int nc, output bit nt, output bit nw);
    nc = c; nt = 0; nw = 0;
    if (cl) nc = 0;
    else if (ld) nc = (v > m) ? m : v;
    else if (en && !dr) begin
      if (c < m) begin nc = c + 1; nt = (nc == m); end
      else if (wp) begin nc = 0; nw = 1; end
    end else if (en && dr) begin
      if (c > 0) begin nc = c - 1; nt = (nc == 0); end
      else if (wp) begin nc = m; nw = 1; end
    end
  endfunction

  task automatic check_all();
    int got[3];
    got[0] = int'(c0);
    got[1] = int'(c1);
    got[2] = int'(c2);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("count%0d", i), got[i], mc[i]);
      chk($sformatf("tc%0d", i), int'(tcv[i]), int'(mt[i]));
      chk($sformatf("wrapped%0d", i), int'(wrv[i]), int'(mw[i]));
      chk($sformatf("at_max%0d", i), int'(amx[i]), int'(mc[i] == mx[i]));
      chk($sformatf("at_min%0d", i), int'(amn[i]), int'(mc[i] == 0));
    end
  endtask

  task automatic tick();
    int nc;
    bit nt, nw;
    @(posedge clock);
    for (int i = 0; i < 3; i++) begin
      step(mx[i], mc[i], clr, load, ena, dir, wrap,
           int'(lv) & wm[i], nc, nt, nw);
      mc[i] = nc; mt[i] = nt; mw[i] = nw;
    end
    #1 check_all();
    @(negedge clock);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mc[i] = 0; mt[i] = 0; mw[i] = 0;
    end
  endtask

  // Called at a negedge; asserts reset between edges.
  task automatic async_reset();
    #2 reset = 1'b0;
    model_reset();
    #1 check_all();
    #1 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    ena = 0; clr = 0; load = 0; dir = 0; wrap = 0; lv = '0;
    model_reset();
    #2 check_all();
    @(negedge clock);
    reset = 1'b1;

    ena = 1;
    repeat (32) tick();
    chk("pre_sat", int'(c0), 32);
    tick();
    chk("sat_hit", int'(c0), 33);
    chk("sat_tc", int'(tcv[0]), 1);
    repeat (7) tick();
    chk("sat_hold", int'(c0), 33);
    chk("sat_notc", int'(tcv[0]), 0);

    wrap = 1;
    tick();
    chk("upwrap_cnt", int'(c0), 0);
    chk("upwrap_pulse", int'(wrv[0]), 1);
    tick();
    chk("upwrap_next", int'(c0), 1);

    ena = 0; wrap = 0; load = 1; lv = 8'd5;
    tick();
    load = 0; dir = 1; ena = 1;
    repeat (5) tick();
    chk("down_zero", int'(c0), 0);
    chk("down_tc", int'(tcv[0]), 1);
    tick();
    chk("down_hold", int'(c0), 0);
    wrap = 1;
    tick();
    chk("downwrap", int'(c0), 33);
    chk("downwrap_pulse", int'(wrv[0]), 1);

    dir = 0; wrap = 0; ena = 0; load = 1; lv = 8'd50;
    tick();
    chk("clamp", int'(c0), 33);
    clr = 1; ena = 1;
    tick();
    chk("clr_prio", int'(c0), 0);
    clr = 0; lv = 8'd7;
    tick();
    chk("load_prio", int'(c0), 7);

    lv = 8'd20; ena = 0;
    tick();
    load = 0;
    async_reset();
    chk("async_cnt", int'(c0), 0);
    ena = 1;
    tick();
    chk("resume", int'(c0), 1);

    ena = 1; dir = 0; wrap = 1;
    repeat (20) tick();

    for (int n = 0; n < 4000; n++) begin
      clr  = ($urandom % 40) == 0;
      load = ($urandom % 25) == 0;
      ena  = ($urandom % 5) != 0;
      if (($urandom % 64) == 0) dir = ~dir;
      if (($urandom % 16) == 0) wrap = ~wrap;
      lv = 8'($urandom);
      if (($urandom % 500) == 0) async_reset();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
